// File: rtl/message_arbiter.sv
// Three-source round-robin message arbiter with a single registered output slot.
// Optional per-source grant counters are built only when MESSAGE_ARBITER_STATS_EN is defined.
module message_arbiter #(
   parameter int unsigned DW = 256
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [DW-1:0] AXIS_IN0_TDATA,
   input  logic          AXIS_IN0_TVALID,
   output logic          AXIS_IN0_TREADY,
   input  logic [DW-1:0] AXIS_IN1_TDATA,
   input  logic          AXIS_IN1_TVALID,
   output logic          AXIS_IN1_TREADY,
   input  logic [DW-1:0] AXIS_IN2_TDATA,
   input  logic          AXIS_IN2_TVALID,
   output logic          AXIS_IN2_TREADY,
   output logic [DW-1:0] AXIS_OUT_TDATA,
   output logic          AXIS_OUT_TVALID,
   input  logic          AXIS_OUT_TREADY,
   output logic [31:0]   GRANT_COUNT0,
   output logic [31:0]   GRANT_COUNT1,
   output logic [31:0]   GRANT_COUNT2
);

   logic [1:0]    last;
   logic [1:0]    grant;
   logic [1:0]    c0, c1, c2;
   logic [2:0]    in_valid;
   logic          any_valid;
   logic          slot_free;
   logic          accept;
   logic [DW-1:0] grant_data;

   function automatic logic [1:0] succ(input logic [1:0] i);
      return (i >= 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   assign in_valid  = {AXIS_IN2_TVALID, AXIS_IN1_TVALID, AXIS_IN0_TVALID};
   assign slot_free = ~AXIS_OUT_TVALID | AXIS_OUT_TREADY;

   // Search order is last+1, last+2, last+3 (mod 3); first valid source wins.
   always_comb begin
      c0        = succ(last);
      c1        = succ(c0);
      c2        = succ(c1);
      grant     = c0;
      any_valid = 1'b0;
      if (in_valid[c0]) begin
         grant     = c0;
         any_valid = 1'b1;
      end else if (in_valid[c1]) begin
         grant     = c1;
         any_valid = 1'b1;
      end else if (in_valid[c2]) begin
         grant     = c2;
         any_valid = 1'b1;
      end
   end

   always_comb begin
      case (grant)
         2'd0:    grant_data = AXIS_IN0_TDATA;
         2'd1:    grant_data = AXIS_IN1_TDATA;
         default: grant_data = AXIS_IN2_TDATA;
      endcase
   end

   // Reset gates the ready path so no beat is accepted while held in reset.
   assign accept          = resetn & slot_free & any_valid;
   assign AXIS_IN0_TREADY = accept & (grant == 2'd0);
   assign AXIS_IN1_TREADY = accept & (grant == 2'd1);
   assign AXIS_IN2_TREADY = accept & (grant == 2'd2);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last            <= 2'd2;
         AXIS_OUT_TVALID <= 1'b0;
         AXIS_OUT_TDATA  <= '0;
      end else begin
         if (accept) begin
            last            <= grant;
            AXIS_OUT_TDATA  <= grant_data;
            AXIS_OUT_TVALID <= 1'b1;
         end else if (AXIS_OUT_TREADY) begin
            AXIS_OUT_TVALID <= 1'b0;
         end
      end
   end

`ifdef MESSAGE_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         GRANT_COUNT0 <= '0;
         GRANT_COUNT1 <= '0;
         GRANT_COUNT2 <= '0;
      end else begin
         if (AXIS_IN0_TREADY) GRANT_COUNT0 <= GRANT_COUNT0 + 32'd1;
         if (AXIS_IN1_TREADY) GRANT_COUNT1 <= GRANT_COUNT1 + 32'd1;
         if (AXIS_IN2_TREADY) GRANT_COUNT2 <= GRANT_COUNT2 + 32'd1;
      end
   end
`else
   assign GRANT_COUNT0 = '0;
   assign GRANT_COUNT1 = '0;
   assign GRANT_COUNT2 = '0;
`endif

endmodule

// File: tb/tb_message_arbiter.sv
// Directed and randomized bench for message_arbiter against a queue-free cycle reference model.
// Expected grant counts follow MESSAGE_ARBITER_STATS_EN.
module tb_message_arbiter;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [DW-1:0] in_d [3];
   logic          in_v [3];
   logic          out_rdy = 1'b0;
   logic          AXIS_IN0_TREADY, AXIS_IN1_TREADY, AXIS_IN2_TREADY;
   logic [DW-1:0] AXIS_OUT_TDATA;
   logic          AXIS_OUT_TVALID;
   logic [31:0]   GRANT_COUNT0, GRANT_COUNT1, GRANT_COUNT2;

   always #5 clk = ~clk;

   message_arbiter #(.DW(DW)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .AXIS_IN0_TDATA  (in_d[0]),
      .AXIS_IN0_TVALID (in_v[0]),
      .AXIS_IN0_TREADY (AXIS_IN0_TREADY),
      .AXIS_IN1_TDATA  (in_d[1]),
      .AXIS_IN1_TVALID (in_v[1]),
      .AXIS_IN1_TREADY (AXIS_IN1_TREADY),
      .AXIS_IN2_TDATA  (in_d[2]),
      .AXIS_IN2_TVALID (in_v[2]),
      .AXIS_IN2_TREADY (AXIS_IN2_TREADY),
      .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
      .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
      .AXIS_OUT_TREADY (out_rdy),
      .GRANT_COUNT0    (GRANT_COUNT0),
      .GRANT_COUNT1    (GRANT_COUNT1),
      .GRANT_COUNT2    (GRANT_COUNT2)
   );

   int          errors = 0;
   int          checks = 0;
   int          m_last;
   bit          m_ov;
   logic [DW-1:0] m_od;
   int          m_src;
   int unsigned m_cnt [3];
   int          acc_src;
   int unsigned seq [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_cnt(input int s);
`ifdef MESSAGE_ARBITER_STATS_EN
      return 64'(m_cnt[s]);
`else
      return 64'd0;
`endif
   endfunction

   // Round robin from the spec: look at (last+1)%3, (last+2)%3, (last+3)%3 when the slot is free.
   function automatic int exp_grant();
      if (m_ov && !out_rdy) return -1;
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (m_last + k) % 3;
         if (in_v[i]) return i;
      end
      return -1;
   endfunction

   task automatic new_data(input int s);
      in_d[s] = {8'(s), 24'(seq[s])};
      seq[s]++;
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(AXIS_OUT_TVALID), 64'(m_ov));
      if (m_ov) chk("out_data", 64'(AXIS_OUT_TDATA), 64'(m_od));
      chk("count0", 64'(GRANT_COUNT0), exp_cnt(0));
      chk("count1", 64'(GRANT_COUNT1), exp_cnt(1));
      chk("count2", 64'(GRANT_COUNT2), exp_cnt(2));
   endtask

   // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
   task automatic cycle();
      int g;
      g = exp_grant();
      #2;
      chk("tready0", 64'(AXIS_IN0_TREADY), 64'(g == 0));
      chk("tready1", 64'(AXIS_IN1_TREADY), 64'(g == 1));
      chk("tready2", 64'(AXIS_IN2_TREADY), 64'(g == 2));
      @(posedge clk);
      #1;
      if (g >= 0) begin
         m_ov  = 1'b1;
         m_od  = in_d[g];
         m_src = g;
         m_last = g;
         m_cnt[g]++;
      end else if (out_rdy) begin
         m_ov = 1'b0;
      end
      acc_src = g;
      check_outputs();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      m_last = 2;
      m_ov   = 1'b0;
      for (int s = 0; s < 3; s++) m_cnt[s] = 0;
      chk("rst_out_valid", 64'(AXIS_OUT_TVALID), 64'd0);
      chk("rst_tready", 64'({AXIS_IN2_TREADY, AXIS_IN1_TREADY, AXIS_IN0_TREADY}), 64'd0);
      chk("rst_counts", 64'(GRANT_COUNT0 | GRANT_COUNT1 | GRANT_COUNT2), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      int held;
      int n0, n2, budget;
      logic [DW-1:0] held_d;
      for (int s = 0; s < 3; s++) begin
         in_v[s] = 1'b0;
         seq[s]  = 1;
         new_data(s);
      end
      acc_src = -1;
      m_src = 0;
      m_od = '0;
      do_reset();

      // Single beat from IN1 with one-cycle latency
      in_d[1] = 32'h0000_0201;
      in_v[1] = 1'b1;
      out_rdy = 1'b1;
      cycle();
      chk("req025_valid", 64'(AXIS_OUT_TVALID), 64'd1);
      chk("req025_data", 64'(AXIS_OUT_TDATA), 64'h201);
      in_v[1] = 1'b0;
      new_data(1);
      cycle();
      chk("req025_drained", 64'(AXIS_OUT_TVALID), 64'd0);

      // All sources valid from reset: strict 0,1,2,0,1,2 with no gaps
      do_reset();
      for (int s = 0; s < 3; s++) in_v[s] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("rr_valid", 64'(AXIS_OUT_TVALID), 64'd1);
         chk("rr_order", 64'(AXIS_OUT_TDATA[31:24]), 64'(k % 3));
         new_data(acc_src);
      end

      // Backpressure: one IN0 beat held stable for 5 cycles
      for (int s = 0; s < 3; s++) in_v[s] = 1'b0;
      cycle();
      in_v[0] = 1'b1;
      out_rdy = 1'b0;
      held_d  = in_d[0];
      cycle();
      new_data(0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("hold_data", 64'(AXIS_OUT_TDATA), 64'(held_d));
         chk("hold_valid", 64'(AXIS_OUT_TVALID), 64'd1);
      end
      in_v[0] = 1'b0;
      out_rdy = 1'b1;
      cycle();

      // Asynchronous reset while a beat is held
      for (int s = 0; s < 3; s++) in_v[s] = 1'b1;
      out_rdy = 1'b0;
      cycle();
      if (acc_src >= 0) new_data(acc_src);
      chk("pre_reset_valid", 64'(AXIS_OUT_TVALID), 64'd1);
      do_reset();
      out_rdy = 1'b1;
      cycle();
      chk("post_reset_grant", 64'(AXIS_OUT_TDATA[31:24]), 64'd0);
      new_data(acc_src);

      // Randomized traffic, including sources withdrawing before grant
      for (int k = 0; k < 400; k++) begin
         for (int s = 0; s < 3; s++) begin
            if (acc_src == s) begin
               new_data(s);
               in_v[s] = ($urandom_range(3, 0) != 0);
            end else if (in_v[s]) begin
               if ($urandom_range(7, 0) == 0) in_v[s] = 1'b0;
            end else if ($urandom_range(1, 0) == 1) begin
               new_data(s);
               in_v[s] = 1'b1;
            end
         end
         out_rdy = ($urandom_range(3, 0) != 0);
         cycle();
      end

      // Grant counters: 10 beats from IN2 and 3 from IN0
      for (int s = 0; s < 3; s++) in_v[s] = 1'b0;
      out_rdy = 1'b1;
      do_reset();
      n0 = 0;
      n2 = 0;
      budget = 0;
      while ((n2 < 10 || n0 < 3) && budget < 60) begin
         in_v[2] = (n2 < 10);
         in_v[0] = (n0 < 3);
         cycle();
         if (acc_src == 2) begin n2++; new_data(2); end
         if (acc_src == 0) begin n0++; new_data(0); end
         budget++;
      end
      chk("req029_done", 64'(n2 == 10 && n0 == 3), 64'd1);
      in_v[0] = 1'b0;
      in_v[2] = 1'b0;
      cycle();
`ifdef MESSAGE_ARBITER_STATS_EN
      chk("req029_cnt0", 64'(GRANT_COUNT0), 64'd3);
      chk("req029_cnt1", 64'(GRANT_COUNT1), 64'd0);
      chk("req029_cnt2", 64'(GRANT_COUNT2), 64'd10);
`else
      chk("req029_cnt0", 64'(GRANT_COUNT0), 64'd0);
      chk("req029_cnt1", 64'(GRANT_COUNT1), 64'd0);
      chk("req029_cnt2", 64'(GRANT_COUNT2), 64'd0);
`endif
      held = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks + held);
      $finish;
   end
endmodule
